multicycle_control: RTL and testbench

- Multi-cycle RV32I main controller. Sequences FETCH/DECODE/EXEC/MEM/WB over shared datapath resources and decodes the 7-bit opcode into the registered control bundle (branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite, jalnk, jalnr).
- Drives req/ready handshakes to instruction and data memory, with a parametrised wait timeout.
- Traps on illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_control_if.sv | 22 ++
 rtl/multicycle_control.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Instruction/data memory request-ready handshake bundle.
// master = controller side, slave = memory side.
interface multicycle_control_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB with traps.
// Optional U-type (LUI/AUIPC) decode and utype output under CTRL_UTYPE_EN.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           insn,
    input  logic                 stall,
    multicycle_control_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_we,
    output logic                 branch,
    output logic                 memread,
    output logic                 memtoreg,
    output logic                 memwrite,
    output logic                 alusrc,
    output logic                 regwrite,
    output logic                 jalnk,
    output logic                 jalnr,
    output logic [1:0]           aluop,
`ifdef CTRL_UTYPE_EN
    output logic                 utype,
`endif
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [2:0]           state_o,
    output logic [CNT_W-1:0]     retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    typedef struct packed {
`ifdef CTRL_UTYPE_EN
        logic       utype;
`endif
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       jalnk;
        logic       jalnr;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_n;
    ctrl_t             bndl;
    ctrl_t             dec;
    logic              dec_ok;
    logic [TO_W-1:0]   wcnt;
    logic [TO_W-1:0]   wcnt_n;
    logic [1:0]        cause;
    logic [1:0]        cause_n;
    logic              ireq;
    logic              to_last;

    assign ireq    = (state == FETCH) && !stall;
    assign to_last = (TIMEOUT > 0) && (wcnt == TO_LAST);

    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        unique case (1'b1)
            insn == 7'b0110011: begin
                dec.regwrite = 1'b1;
                dec.aluop    = 2'b10;
            end
            insn == 7'b0010011: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b11;
            end
            insn == 7'b0000011: begin
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            insn == 7'b0100011: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            insn == 7'b1100011: begin
                dec.branch = 1'b1;
                dec.aluop  = 2'b01;
            end
            insn == 7'b1101111: begin
                dec.jalnk    = 1'b1;
                dec.regwrite = 1'b1;
            end
            insn == 7'b1100111: begin
                dec.jalnr    = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
`ifdef CTRL_UTYPE_EN
            insn == 7'b0110111,
            insn == 7'b0010111: begin
                dec.utype    = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
`endif
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        cause_n = cause;
        unique case (state)
            FETCH: begin
                if (ireq && mem.imem_ready) begin
                    state_n = DECODE;
                end else if (ireq && to_last) begin
                    state_n = TRAP;
                    cause_n = 2'b10;
                end
            end
            DECODE: begin
                state_n = dec_ok ? EXEC : TRAP;
                if (!dec_ok) cause_n = 2'b01;
            end
            EXEC: begin
                state_n = (bndl.memread || bndl.memwrite) ? MEM : WB;
            end
            MEM: begin
                if (mem.dmem_ready) begin
                    state_n = WB;
                end else if (to_last) begin
                    state_n = TRAP;
                    cause_n = 2'b11;
                end
            end
            WB:      state_n = FETCH;
            TRAP:    state_n = TRAP;
            default: state_n = FETCH;
        endcase
    end

    // Wait counter only runs while a request sits unanswered in one state.
    always_comb begin
        wcnt_n = '0;
        if (state_n == state) begin
            if ((ireq && !mem.imem_ready) ||
                (state == MEM && !mem.dmem_ready)) begin
                wcnt_n = wcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt    <= '0;
            bndl    <= '0;
            cause   <= '0;
            retired <= '0;
        end else begin
            wcnt  <= wcnt_n;
            cause <= cause_n;
            if (state == DECODE) bndl <= dec_ok ? dec : '0;
            if (state == WB) retired <= retired + CNT_W'(1);
        end
    end

    // Handshakes and strobes are forced low while reset is asserted.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_we       = 1'b0;
        trap         = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    mem.imem_req = !stall;
                    ir_write     = !stall && mem.imem_ready;
                end
                MEM:  mem.dmem_req = 1'b1;
                WB: begin
                    pc_write = 1'b1;
                    reg_we   = bndl.regwrite;
                end
                TRAP:    trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign branch     = bndl.branch;
    assign memread    = bndl.memread;
    assign memtoreg   = bndl.memtoreg;
    assign memwrite   = bndl.memwrite;
    assign alusrc     = bndl.alusrc;
    assign regwrite   = bndl.regwrite;
    assign jalnk      = bndl.jalnk;
    assign jalnr      = bndl.jalnr;
    assign aluop      = bndl.aluop;
`ifdef CTRL_UTYPE_EN
    assign utype      = bndl.utype;
`endif
    assign trap_cause = cause;
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus
// randomized instruction/wait streams against a sequence-level model.
module tb_multicycle_control;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       insn;
    logic             stall;
    logic             ir_write, pc_write, reg_we;
    logic             branch, memread, memtoreg, memwrite;
    logic             alusrc, regwrite, jalnk, jalnr;
    logic [1:0]       aluop;
    logic             utype_obs;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retired;

    int n_chk  = 0;
    int n_fail = 0;

    logic [10:0]      mb;
    logic [CNT_W-1:0] mret;

    multicycle_control_if mif ();

    multicycle_control #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (8),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .insn       (insn),
        .stall      (stall),
        .mem        (mif),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_we     (reg_we),
        .branch     (branch),
        .memread    (memread),
        .memtoreg   (memtoreg),
        .memwrite   (memwrite),
        .alusrc     (alusrc),
        .regwrite   (regwrite),
        .jalnk      (jalnk),
        .jalnr      (jalnr),
        .aluop      (aluop),
`ifdef CTRL_UTYPE_EN
        .utype      (utype_obs),
`endif
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_o    (state_o),
        .retired    (retired)
    );

`ifndef CTRL_UTYPE_EN
    assign utype_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    // Decode table: {utype,branch,memread,memtoreg,memwrite,alusrc,
    // regwrite,jalnk,jalnr,aluop}
    function automatic logic [10:0] ref_bundle(input logic [6:0] op,
                                               output bit legal);
        logic ut, br, mr, mtr, mw, as, rw, jk, jr;
        logic [1:0] ao;
        {ut, br, mr, mtr, mw, as, rw, jk, jr} = '0;
        ao = 2'b00;
        legal = 1'b1;
        case (op)
            7'b0110011: begin rw = 1; ao = 2'b10; end
            7'b0010011: begin rw = 1; as = 1; ao = 2'b11; end
            7'b0000011: begin mr = 1; mtr = 1; as = 1; rw = 1; end
            7'b0100011: begin mw = 1; as = 1; end
            7'b1100011: begin br = 1; ao = 2'b01; end
            7'b1101111: begin jk = 1; rw = 1; end
            7'b1100111: begin jr = 1; rw = 1; as = 1; end
`ifdef CTRL_UTYPE_EN
            7'b0110111, 7'b0010111: begin ut = 1; rw = 1; as = 1; end
`endif
            default: legal = 1'b0;
        endcase
        return {ut, br, mr, mtr, mw, as, rw, jk, jr, ao};
    endfunction

    task automatic do_reset();
        logic [19:0] obs;
        reset = 1'b1;
        stall = 1'b0;
        insn  = 7'd0;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        obs = {state_o, mif.imem_req, mif.dmem_req, ir_write, pc_write,
               reg_we, trap, trap_cause, utype_obs, branch, memread,
               memtoreg, memwrite, alusrc, regwrite, jalnk, jalnr, aluop};
        n_chk++;
        if (obs !== 20'd0 || retired !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got %h ret %0d want 0", obs, retired);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mb   = '0;
        mret = '0;
    endtask

    // Drives one instruction from FETCH; iw/dw = ready delay in cycles,
    // a delay >= TIMEOUT means ready never arrives.
    task automatic run_insn(input logic [6:0] op, input int iw, input int dw);
        int          es[$];
        logic [10:0] nb;
        bit          legal;
        logic [1:0]  ec;
        int          ms;
        logic [5:0]  es_str, ob_str;
        logic [10:0] ob_b;
        nb = ref_bundle(op, legal);
        ec = 2'b00;
        ms = iw + 3;
        if (iw >= TIMEOUT) begin
            repeat (TIMEOUT) es.push_back(0);
            es.push_back(7);
            ec = 2'b10;
        end else begin
            repeat (iw + 1) es.push_back(0);
            es.push_back(1);
            if (!legal) begin
                es.push_back(7);
                ec = 2'b01;
            end else begin
                es.push_back(2);
                if (nb[8] || nb[6]) begin
                    if (dw >= TIMEOUT) begin
                        repeat (TIMEOUT) es.push_back(3);
                        es.push_back(7);
                        ec = 2'b11;
                    end else begin
                        repeat (dw + 1) es.push_back(3);
                        es.push_back(4);
                    end
                end else begin
                    es.push_back(4);
                end
            end
        end
        insn = op;
        for (int i = 0; i < es.size(); i++) begin
            mif.imem_ready = (es[i] == 0) && (i == iw);
            mif.dmem_ready = (es[i] == 3) && (i == ms + dw);
            @(negedge clk);
            n_chk++;
            if (state_o !== es[i][2:0]) begin
                n_fail++;
                $display("FAIL state op=%b cyc%0d got %0d want %0d",
                         op, i, state_o, es[i]);
            end
            es_str = {es[i] == 0, es[i] == 3,
                      es[i] == 0 && mif.imem_ready, es[i] == 4,
                      es[i] == 4 && mb[4], es[i] == 7};
            ob_str = {mif.imem_req, mif.dmem_req, ir_write, pc_write,
                      reg_we, trap};
            n_chk++;
            if (ob_str !== es_str) begin
                n_fail++;
                $display("FAIL strobes op=%b cyc%0d got %b want %b",
                         op, i, ob_str, es_str);
            end
            ob_b = {utype_obs, branch, memread, memtoreg, memwrite, alusrc,
                    regwrite, jalnk, jalnr, aluop};
            n_chk++;
            if (ob_b !== mb) begin
                n_fail++;
                $display("FAIL bundle op=%b cyc%0d got %b want %b",
                         op, i, ob_b, mb);
            end
            n_chk++;
            if (retired !== mret) begin
                n_fail++;
                $display("FAIL retired cyc%0d got %0d want %0d",
                         i, retired, mret);
            end
            if (es[i] == 7) begin
                n_chk++;
                if (trap_cause !== ec) begin
                    n_fail++;
                    $display("FAIL cause op=%b got %b want %b",
                             op, trap_cause, ec);
                end
            end
            @(posedge clk); #1;
            if (es[i] == 1) mb = legal ? nb : 11'd0;
            if (es[i] == 4) mret = mret + 1'b1;
        end
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        if (ec != 2'b00) begin
            for (int k = 0; k < 4; k++) begin
                mif.imem_ready = 1'($urandom);
                mif.dmem_ready = 1'($urandom);
                @(negedge clk);
                n_chk++;
                if ({state_o, trap, trap_cause, mif.imem_req, mif.dmem_req,
                     ir_write, pc_write, reg_we} !== {3'd7, 1'b1, ec, 5'd0}) begin
                    n_fail++;
                    $display("FAIL trap_hold k%0d got st%0d tr%b c%b", k,
                             state_o, trap, trap_cause);
                end
                @(posedge clk); #1;
            end
            do_reset();
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_rtype();
        run_insn(7'b0110011, 0, 0);
    endtask

    task automatic test_load_wait();
        run_insn(7'b0000011, 0, 3);
    endtask

    task automatic test_branch_store();
        run_insn(7'b1100011, 1, 0);
        run_insn(7'b0100011, 0, 1);
    endtask

    task automatic test_illegal();
        run_insn(7'b1100110, 0, 0);
    endtask

    task automatic test_timeout();
        run_insn(7'b0010011, TIMEOUT, 0);
        run_insn(7'b0010011, TIMEOUT - 1, 0);
        run_insn(7'b0100011, 0, TIMEOUT - 1);
        run_insn(7'b0000011, 0, TIMEOUT);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int c = 0; c < 40; c++) begin
            mif.imem_ready = 1'($urandom);
            @(negedge clk);
            n_chk++;
            if ({state_o, mif.imem_req, ir_write, trap} !== 6'd0) begin
                n_fail++;
                $display("FAIL stall c%0d got st%0d req%b ir%b tr%b", c,
                         state_o, mif.imem_req, ir_write, trap);
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        mif.imem_ready = 1'b0;
        run_insn(7'b1101111, TIMEOUT - 1, 0);
    endtask

    task automatic test_utype();
        run_insn(7'b0110111, 0, 0);
        run_insn(7'b0010111, 2, 0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [9];
        logic [6:0] op;
        int         iw, dw;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = ops[$urandom_range(0, 8)];
            iw = ($urandom_range(0, 15) == 0) ? TIMEOUT : $urandom_range(0, 4);
            dw = ($urandom_range(0, 15) == 0) ? TIMEOUT : $urandom_range(0, 4);
            run_insn(op, iw, dw);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        insn  = 7'd0;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch_store();
        test_illegal();
        test_timeout();
        test_stall();
        test_utype();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
